// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Round-robin arbiter sharing the single data_ram port between the CPU data
// port (master 0) and a second bus master (master 1, e.g. DMA/debug loader).
// A grant is held from the sampled request until the RAM signals data_ready
// (or the granted master drops its request), then released for one IDLE cycle.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   defined   : a watchdog aborts a transaction after TIMEOUT_CYCLES BUSY
//               cycles without data_ready and pulses the granted m*_err_o.
//   undefined : no watchdog; m*_err_o tied low; BUSY waits indefinitely.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   m{0,1}_ce_i            master request, held until m*_ready_o
//   m{0,1}_we/addr/sel/data_i  master write enable, address, byte sel, wdata
//   m{0,1}_data_o          master read data (valid with m*_ready_o)
//   m{0,1}_ready_o         master completion pulse
//   m{0,1}_err_o           master timeout pulse
//   ram_ce/we/addr/sel/data_o  RAM request side
//   ram_data_i, ram_data_ready RAM read data and completion
//   busy_o                 transaction in progress
//   gnt_o                  current or last grant index
//
// The RAM request and master response paths are combinational on the
// registered state so that a zero-wait RAM completes in the first BUSY cycle.
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (CPU data port)
  input  logic              m0_ce_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ready_o,
  output logic              m0_err_o,
  // master 1 (secondary bus master)
  input  logic              m1_ce_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ready_o,
  output logic              m1_err_o,
  // shared RAM port
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_data_ready,
  // status
  output logic              busy_o,
  output logic              gnt_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0] st_q, st_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;

  logic       is_busy;
  logic       gnt_ce;
  logic       rdy_hit;
  logic       abort_hit;
  logic       to_hit;

  // Request of whichever master currently holds the grant.
  assign is_busy   = (st_q == ST_BUSY);
  assign gnt_ce    = gnt_q ? m1_ce_i : m0_ce_i;
  // Completion only counts while the granted master still requests; a reset
  // in the same cycle drops the transaction without a ready pulse.
  assign rdy_hit   = is_busy & gnt_ce & ram_data_ready & ~rst;
  assign abort_hit = is_busy & ~gnt_ce;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Watchdog expiry; a ready in the same cycle takes precedence.
  assign to_hit = is_busy & gnt_ce & ~ram_data_ready & ~rst &
                  (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

  // Watchdog next state: cleared on BUSY entry, counts BUSY cycles.
  always_comb begin
    wdog_d = wdog_q;
    if (!is_busy) begin
      wdog_d = '0;
    end else if (!ram_data_ready) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign unused_timeout = |32'(TIMEOUT_CYCLES);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
    end
  end

  // Next-state logic: round-robin pick in IDLE, release on ready/abort/timeout.
  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    last_d = last_q;
    case (st_q)
      ST_IDLE: begin
        if (m0_ce_i && m1_ce_i) begin
          // Contention: favour the master that was not served last.
          gnt_d = ~last_q;
          st_d  = ST_BUSY;
        end else if (m0_ce_i) begin
          gnt_d = 1'b0;
          st_d  = ST_BUSY;
        end else if (m1_ce_i) begin
          gnt_d = 1'b1;
          st_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (rdy_hit || abort_hit || to_hit) begin
          st_d   = ST_IDLE;
          last_d = gnt_q;
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // RAM request mux and per-master response routing.
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    m0_ready_o = 1'b0;
    m0_data_o  = '0;
    m0_err_o   = 1'b0;
    m1_ready_o = 1'b0;
    m1_data_o  = '0;
    m1_err_o   = 1'b0;
    if (is_busy) begin
      // Chip enable follows the granted request so an abort drops it at once.
      ram_ce_o   = gnt_ce & ~to_hit;
      ram_we_o   = gnt_q ? m1_we_i   : m0_we_i;
      ram_addr_o = gnt_q ? m1_addr_i : m0_addr_i;
      ram_sel_o  = gnt_q ? m1_sel_i  : m0_sel_i;
      ram_data_o = gnt_q ? m1_data_i : m0_data_i;
      if (gnt_q) begin
        m1_ready_o = rdy_hit;
        m1_err_o   = to_hit;
        if (rdy_hit) begin
          m1_data_o = ram_data_i;
        end
      end else begin
        m0_ready_o = rdy_hit;
        m0_err_o   = to_hit;
        if (rdy_hit) begin
          m0_data_o = ram_data_i;
        end
      end
    end
  end

  assign busy_o = is_busy;
  assign gnt_o  = gnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench: per-cycle vector table {inputs, expected outputs} plus
// hand-written sequences for contention ordering and watchdog timeout.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        rst;
    logic        m0_ce;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [3:0]  m0_sel;
    logic [31:0] m0_data;
    logic        m1_ce;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [3:0]  m1_sel;
    logic [31:0] m1_data;
    logic [31:0] rdata;
    logic        rrdy;
  } in_t;

  typedef struct packed {
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_data;
    logic        m0_rdy;
    logic [31:0] m0_data;
    logic        m0_err;
    logic        m1_rdy;
    logic [31:0] m1_data;
    logic        m1_err;
    logic        busy;
    logic        gnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        m0_ce_i, m0_we_i, m1_ce_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;
  logic        ram_data_ready;
  logic        busy_o, gnt_o;

  int tests;
  int fails;

  vec_t tbl [0:18];

  data_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m0_ce_i(m0_ce_i),
    .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i),
    .m0_sel_i(m0_sel_i),
    .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o),
    .m0_ready_o(m0_ready_o),
    .m0_err_o(m0_err_o),
    .m1_ce_i(m1_ce_i),
    .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i),
    .m1_sel_i(m1_sel_i),
    .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o),
    .m1_ready_o(m1_ready_o),
    .m1_err_o(m1_err_o),
    .ram_ce_o(ram_ce_o),
    .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o),
    .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i),
    .ram_data_ready(ram_data_ready),
    .busy_o(busy_o),
    .gnt_o(gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mi(
    input logic rs,
    input logic c0, input logic w0, input logic [31:0] a0,
    input logic [3:0] s0, input logic [31:0] d0,
    input logic c1, input logic w1, input logic [31:0] a1,
    input logic [3:0] s1, input logic [31:0] d1,
    input logic [31:0] rd, input logic rr);
    in_t x;
    x.rst = rs;
    x.m0_ce = c0; x.m0_we = w0; x.m0_addr = a0; x.m0_sel = s0; x.m0_data = d0;
    x.m1_ce = c1; x.m1_we = w1; x.m1_addr = a1; x.m1_sel = s1; x.m1_data = d1;
    x.rdata = rd; x.rrdy = rr;
    return x;
  endfunction

  function automatic out_t mo(
    input logic ce, input logic we, input logic [31:0] a,
    input logic [3:0] s, input logic [31:0] d,
    input logic r0, input logic [31:0] d0,
    input logic r1, input logic [31:0] d1,
    input logic bsy, input logic g);
    out_t y;
    y.ram_ce = ce; y.ram_we = we; y.ram_addr = a; y.ram_sel = s; y.ram_data = d;
    y.m0_rdy = r0; y.m0_data = d0; y.m0_err = 1'b0;
    y.m1_rdy = r1; y.m1_data = d1; y.m1_err = 1'b0;
    y.busy = bsy; y.gnt = g;
    return y;
  endfunction

  function automatic out_t zero_out(input logic g);
    return mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
  endfunction

  task automatic apply(input in_t x);
    rst            = x.rst;
    m0_ce_i        = x.m0_ce;
    m0_we_i        = x.m0_we;
    m0_addr_i      = x.m0_addr;
    m0_sel_i       = x.m0_sel;
    m0_data_i      = x.m0_data;
    m1_ce_i        = x.m1_ce;
    m1_we_i        = x.m1_we;
    m1_addr_i      = x.m1_addr;
    m1_sel_i       = x.m1_sel;
    m1_data_i      = x.m1_data;
    ram_data_i     = x.rdata;
    ram_data_ready = x.rrdy;
  endtask

  function automatic out_t sample();
    out_t y;
    y.ram_ce = ram_ce_o; y.ram_we = ram_we_o; y.ram_addr = ram_addr_o;
    y.ram_sel = ram_sel_o; y.ram_data = ram_data_o;
    y.m0_rdy = m0_ready_o; y.m0_data = m0_data_o; y.m0_err = m0_err_o;
    y.m1_rdy = m1_ready_o; y.m1_data = m1_data_o; y.m1_err = m1_err_o;
    y.busy = busy_o; y.gnt = gnt_o;
    return y;
  endfunction

  task automatic chk_vec(input string name, input out_t act, input out_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clocked vector per row: drive after the edge, compare mid-cycle.
  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      @(posedge clk);
      #1;
      apply(tbl[r].i);
      @(negedge clk);
      chk_vec($sformatf("row%0d", r), sample(), tbl[r].e);
    end
  endtask

  in_t idle_in;

  initial begin
    tests = 0;
    fails = 0;
    idle_in = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset then idle; single m0 read; ready while IDLE ignored.
    tbl[0]  = '{i: idle_in, e: zero_out(0)};
    tbl[1]  = '{i: mi(0, 1, 0, 32'h10, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0), e: zero_out(0)};
    tbl[2]  = '{i: mi(0, 1, 0, 32'h10, 4'hF, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0),
                e: mo(1, 0, 32'h10, 4'hF, 0, 0, 0, 0, 0, 1, 0)};
    tbl[3]  = '{i: mi(0, 1, 0, 32'h10, 4'hF, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1),
                e: mo(1, 0, 32'h10, 4'hF, 0, 1, 32'hDEADBEEF, 0, 0, 1, 0)};
    tbl[4]  = '{i: mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 1), e: zero_out(0)};
    // Reset restores last=1, then simultaneous requests: m0 first, then m1.
    tbl[5]  = '{i: mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e: zero_out(0)};
    tbl[6]  = '{i: mi(0, 1, 1, 32'h20, 4'hF, 32'h11223344, 1, 0, 32'h24, 4'hF, 0, 0, 0),
                e: zero_out(0)};
    tbl[7]  = '{i: mi(0, 1, 1, 32'h20, 4'hF, 32'h11223344, 1, 0, 32'h24, 4'hF, 0, 32'hAAAA0000, 1),
                e: mo(1, 1, 32'h20, 4'hF, 32'h11223344, 1, 32'hAAAA0000, 0, 0, 1, 0)};
    tbl[8]  = '{i: mi(0, 0, 0, 0, 0, 0, 1, 0, 32'h24, 4'hF, 0, 0, 0), e: zero_out(0)};
    tbl[9]  = '{i: mi(0, 0, 0, 0, 0, 0, 1, 0, 32'h24, 4'hF, 0, 32'hCAFEF00D, 1),
                e: mo(1, 0, 32'h24, 4'hF, 0, 0, 0, 1, 32'hCAFEF00D, 1, 1)};
    tbl[10] = '{i: idle_in, e: zero_out(1)};
    // Abort: m1 drops ce_i while granted; late RAM ready must not reach it.
    tbl[11] = '{i: mi(0, 0, 0, 0, 0, 0, 1, 0, 32'h30, 4'hF, 0, 0, 0), e: zero_out(1)};
    tbl[12] = '{i: mi(0, 0, 0, 0, 0, 0, 1, 0, 32'h30, 4'hF, 0, 0, 0),
                e: mo(1, 0, 32'h30, 4'hF, 0, 0, 0, 0, 0, 1, 1)};
    tbl[13] = '{i: mi(0, 0, 0, 0, 0, 0, 0, 0, 32'h30, 4'hF, 0, 32'h99, 1),
                e: mo(0, 0, 32'h30, 4'hF, 0, 0, 0, 0, 0, 1, 1)};
    tbl[14] = '{i: idle_in, e: zero_out(1)};
    // Reset mid-BUSY with m1 granted: no ready, back to gnt=0 idle.
    tbl[15] = '{i: mi(0, 0, 0, 0, 0, 0, 1, 1, 32'h44, 4'h3, 32'h55667788, 0, 0), e: zero_out(1)};
    tbl[16] = '{i: mi(0, 0, 0, 0, 0, 0, 1, 1, 32'h44, 4'h3, 32'h55667788, 0, 0),
                e: mo(1, 1, 32'h44, 4'h3, 32'h55667788, 0, 0, 0, 0, 1, 1)};
    tbl[17] = '{i: mi(1, 0, 0, 0, 0, 0, 1, 1, 32'h44, 4'h3, 32'h55667788, 32'h77, 1),
                e: mo(1, 1, 32'h44, 4'h3, 32'h55667788, 0, 0, 0, 0, 1, 1)};
    tbl[18] = '{i: idle_in, e: zero_out(0)};

    // Power-on reset held for two edges.
    apply(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    run_rows(0, 10);

    // Continuous contention with a zero-wait RAM: grants alternate 0,1,...
    begin
      logic exp_g [0:7];
      for (int k = 0; k < 8; k++) exp_g[k] = 1'(k % 2);
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #1;
        apply(mi(0, 1, 0, 32'h100, 4'hF, 0, 1, 0, 32'h200, 4'hF, 0, 32'(k), 1));
        @(negedge clk);
        chk($sformatf("cont%0d_idle_busy", k), 32'(busy_o), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk($sformatf("cont%0d_gnt", k), 32'(gnt_o), 32'(exp_g[k]));
        chk($sformatf("cont%0d_addr", k), ram_addr_o, exp_g[k] ? 32'h200 : 32'h100);
        chk($sformatf("cont%0d_ready", k), {30'b0, m1_ready_o, m0_ready_o},
            exp_g[k] ? 32'h2 : 32'h1);
      end
    end

    run_rows(11, 18);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: m0 granted, RAM silent; err in 4th BUSY cycle, then m1 served.
    @(posedge clk);
    #1;
    apply(mi(0, 1, 0, 32'h50, 4'hF, 0, 1, 0, 32'h60, 4'hF, 0, 0, 0));
    @(negedge clk);
    chk("to_idle_busy", 32'(busy_o), 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("to_c%0d_err", c), {30'b0, m1_err_o, m0_err_o}, (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("to_c%0d_ce", c), 32'(ram_ce_o), (c == 4) ? 32'h0 : 32'h1);
      chk($sformatf("to_c%0d_busy", c), {30'b0, busy_o, gnt_o}, 32'h2);
    end
    @(posedge clk);
    #1;
    apply(mi(0, 0, 0, 0, 0, 0, 1, 0, 32'h60, 4'hF, 0, 0, 0));
    @(negedge clk);
    chk("to_after_busy", {30'b0, busy_o, m0_err_o}, 32'h0);
    @(posedge clk);
    #1;
    apply(mi(0, 0, 0, 0, 0, 0, 1, 0, 32'h60, 4'hF, 0, 32'h5A5A, 1));
    @(negedge clk);
    chk("to_m1_gnt", {30'b0, busy_o, gnt_o}, 32'h3);
    chk("to_m1_ready", 32'(m1_ready_o), 32'h1);
    chk("to_m1_data", m1_data_o, 32'h5A5A);
    @(posedge clk);
    #1;
    apply(idle_in);
    @(negedge clk);
    chk("to_final_idle", 32'(busy_o), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
